dmem_arbiter: RTL

Two-master arbiter for the single data-BRAM port used by the MEM stage. Shares the port between the CPU MEM stage (master 0) and a DMA/debug loader (master 1). Grants are combinational and follow CPU-first priority with DMA starvation protection and a bounded DMA burst lock. The arbiter drives the BRAM enable, write-enable, address and write data, and returns per-master read-valid strobes one cycle after a granted read.

---
 rtl/dmem_if.sv | 31 +++
 rtl/dmem_arbiter.sv | 60 ++++++
 2 files changed

// File: rtl/dmem_if.sv
// dmem_if: request/grant/read-return and BRAM port bundle shared by the data-memory arbiter and its masters
interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-first arbiter for the shared data BRAM port with DMA starvation guard and bounded DMA lock
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int STARVE_LIM = 4,
  parameter int LOCK_MAX   = 16
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  localparam int WW = $clog2(STARVE_LIM + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t            state;
  logic [WW-1:0]     wait_cnt;
  logic [LW-1:0]     lock_cnt;
  logic              starve, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  assign starve  = wait_cnt == WW'(STARVE_LIM);
  assign cpu_gnt = state == ARB && bus.cpu_req && !(starve && bus.dma_req);
  // in LOCKED cpu_gnt is already 0, so the DMA simply gets whatever it asks for
  assign dma_gnt = bus.dma_req && !cpu_gnt;
  always_comb begin
    addr  = cpu_gnt ? bus.cpu_addr  : dma_gnt ? bus.dma_addr  : '0;
    wdata = cpu_gnt ? bus.cpu_wdata : dma_gnt ? bus.dma_wdata : '0;
  end
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt;
  assign bus.mem_en     = cpu_gnt || dma_gnt;
  assign bus.mem_we     = cpu_gnt ? bus.cpu_we : dma_gnt && bus.dma_we;
  assign bus.mem_addr   = addr;
  assign bus.mem_wdata  = wdata;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dma_rvalid = dma_rvalid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ARB;
      wait_cnt   <= '0;
      lock_cnt   <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt && !bus.cpu_we;
      dma_rvalid <= dma_gnt && !bus.dma_we;
      wait_cnt   <= (dma_gnt || !bus.dma_req) ? '0 : starve ? wait_cnt : wait_cnt + 1'b1;
      if (state == ARB) begin
        state    <= (dma_gnt && bus.dma_lock) ? LOCKED : ARB;
        lock_cnt <= '0;
      end else if (!bus.dma_lock || lock_cnt == LW'(LOCK_MAX - 1)) begin
        state    <= ARB;
        lock_cnt <= '0;
      end else
        lock_cnt <= lock_cnt + 1'b1;
    end
endmodule
